// File: rtl/z80_core_ext.sv
// Multi-cycle Z80-subset core: one bus step per clock, cp=0 is the opcode fetch.
// Adds wait handshake, full flag register, jumps, CALL/RET, PUSH/POP and HALT.
module z80_core_ext #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_SP = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] address,
    input  logic [7:0]  in,
    output logic [7:0]  out,
    output logic        we,
    input  logic        ready,
    output logic        m1,
    output logic        halted
);

    localparam logic [2:0] R_B = 3'd0;
    localparam logic [2:0] R_C = 3'd1;
    localparam logic [2:0] R_D = 3'd2;
    localparam logic [2:0] R_E = 3'd3;
    localparam logic [2:0] R_H = 3'd4;
    localparam logic [2:0] R_L = 3'd5;
    localparam logic [2:0] R_F = 3'd6;
    localparam logic [2:0] R_A = 3'd7;

    typedef enum logic [2:0] {
        STEP_FETCH = 3'd0,
        STEP_1     = 3'd1,
        STEP_2     = 3'd2,
        STEP_3     = 3'd3,
        STEP_4     = 3'd4
    } step_t;

    typedef enum logic [4:0] {
        K_NOP, K_LDRRNN, K_INCDEC, K_LDRN, K_LDHLN, K_LDRR, K_LDRHL, K_LDHLR,
        K_ALUR, K_ALUHL, K_ALUN, K_JP, K_JPCC, K_JR, K_CALL, K_RET, K_PUSH,
        K_POP, K_HALT
    } kind_t;

    // Register file slots follow the r encoding; slot 6 ((HL) in r encoding) holds F.
    logic [7:0][7:0] rf, rf_n;
    logic [15:0]     pc, pc_n, sp, sp_n, tmp, tmp_n;
    logic [7:0]      opc, opc_n;
    step_t           cp, cp_n;
    logic            halted_n;

    logic [7:0]  op;
    logic [1:0]  x, p;
    logic [2:0]  y, z;
    logic        q;
    kind_t       kind;
    logic [15:0] hl, rr, qq, alu_out, pw_val;
    logic [7:0]  alu_v;
    logic        cc_flag, cc_true, pw_en, pw_af, alu_wr;

    // Returns {new A, new F}; A is left unchanged for CP.
    function automatic logic [15:0] alu(input logic [2:0] fn, input logic [7:0] a,
                                        input logic [7:0] v, input logic cf);
        logic [8:0] r9;
        logic [4:0] h5;
        logic [7:0] r;
        logic       cin, sub, arith, ovf, hf, pv;
        cin   = (fn == 3'd1 || fn == 3'd3) ? cf : 1'b0;
        sub   = (fn == 3'd2 || fn == 3'd3 || fn == 3'd7);
        arith = (fn < 3'd4) || (fn == 3'd7);
        if (sub) begin
            r9  = {1'b0, a} - {1'b0, v} - 9'(cin);
            h5  = {1'b0, a[3:0]} - {1'b0, v[3:0]} - 5'(cin);
            ovf = (a[7] != v[7]) && (r9[7] != a[7]);
        end else begin
            r9  = {1'b0, a} + {1'b0, v} + 9'(cin);
            h5  = {1'b0, a[3:0]} + {1'b0, v[3:0]} + 5'(cin);
            ovf = (a[7] == v[7]) && (r9[7] != a[7]);
        end
        case (fn)
            3'd4:    r = a & v;
            3'd5:    r = a ^ v;
            3'd6:    r = a | v;
            default: r = r9[7:0];
        endcase
        hf = arith ? h5[4] : (fn == 3'd4);
        pv = arith ? ovf : ~^r;
        return {(fn == 3'd7) ? a : r, r[7], (r == 8'h00), 1'b0, hf, 1'b0, pv, sub,
                arith & r9[8]};
    endfunction

    assign op = (cp == STEP_FETCH) ? in : opc;
    assign x  = op[7:6];
    assign y  = op[5:3];
    assign z  = op[2:0];
    assign p  = op[5:4];
    assign q  = op[3];
    assign m1 = (cp == STEP_FETCH);
    assign hl = {rf[R_H], rf[R_L]};
    assign qq = (p == 2'd3) ? {rf[R_A], rf[R_F]} : rr;

    always_comb begin
        case (p)
            2'd0:    rr = {rf[R_B], rf[R_C]};
            2'd1:    rr = {rf[R_D], rf[R_E]};
            2'd2:    rr = hl;
            default: rr = sp;
        endcase
    end

    // Condition order NZ,Z,NC,C,PO,PE,P,M: pairs share a flag, y[0] selects polarity.
    always_comb begin
        case (y[2:1])
            2'd0:    cc_flag = rf[R_F][6];
            2'd1:    cc_flag = rf[R_F][0];
            2'd2:    cc_flag = rf[R_F][2];
            default: cc_flag = rf[R_F][7];
        endcase
        cc_true = y[0] ? cc_flag : ~cc_flag;
    end

    assign alu_v   = (cp == STEP_FETCH) ? rf[z] : in;
    assign alu_out = alu(y, rf[R_A], alu_v, rf[R_F][0]);

    always_comb begin
        kind = K_NOP;
        case (x)
            2'd0: begin
                if (op == 8'h18)               kind = K_JR;
                else if (z == 3'd1 && !q)      kind = K_LDRRNN;
                else if (z == 3'd3)            kind = K_INCDEC;
                else if (z == 3'd6)            kind = (y == 3'd6) ? K_LDHLN : K_LDRN;
            end
            2'd1: begin
                if (op == 8'h76)               kind = K_HALT;
                else if (z == 3'd6)            kind = K_LDRHL;
                else if (y == 3'd6)            kind = K_LDHLR;
                else                           kind = K_LDRR;
            end
            2'd2: kind = (z == 3'd6) ? K_ALUHL : K_ALUR;
            default: begin
                if (op == 8'hC3)               kind = K_JP;
                else if (op == 8'hCD)          kind = K_CALL;
                else if (op == 8'hC9)          kind = K_RET;
                else if (z == 3'd6)            kind = K_ALUN;
                else if (z == 3'd2)            kind = K_JPCC;
                else if (z == 3'd5 && !q)      kind = K_PUSH;
                else if (z == 3'd1 && !q)      kind = K_POP;
            end
        endcase
    end

    // Next-state and bus outputs for the current step.
    always_comb begin
        pc_n     = pc;
        sp_n     = sp;
        rf_n     = rf;
        tmp_n    = tmp;
        opc_n    = opc;
        cp_n     = STEP_FETCH;
        halted_n = halted;
        address  = pc;
        we       = 1'b0;
        out      = 8'h00;
        pw_en    = 1'b0;
        pw_af    = 1'b0;
        pw_val   = 16'h0000;
        alu_wr   = 1'b0;

        case (cp)
            STEP_FETCH: begin
                if (!halted) begin
                    opc_n = in;
                    pc_n  = pc + 16'd1;
                    case (kind)
                        K_NOP:    cp_n = STEP_FETCH;
                        K_HALT: begin
                            pc_n     = pc;
                            halted_n = 1'b1;
                        end
                        K_INCDEC: begin
                            pw_en  = 1'b1;
                            pw_val = q ? rr - 16'd1 : rr + 16'd1;
                        end
                        K_LDRR:   rf_n[y] = rf[z];
                        K_ALUR:   alu_wr = 1'b1;
                        default:  cp_n = STEP_1;
                    endcase
                end
            end
            STEP_1: begin
                case (kind)
                    K_LDRRNN, K_LDHLN, K_JP, K_JPCC, K_CALL: begin
                        tmp_n[7:0] = in;
                        pc_n       = pc + 16'd1;
                        cp_n       = STEP_2;
                    end
                    K_LDRN: begin
                        rf_n[y] = in;
                        pc_n    = pc + 16'd1;
                    end
                    K_LDRHL: begin
                        address = hl;
                        rf_n[y] = in;
                    end
                    K_LDHLR: begin
                        address = hl;
                        we      = 1'b1;
                        out     = rf[z];
                    end
                    K_ALUHL: begin
                        address = hl;
                        alu_wr  = 1'b1;
                    end
                    K_ALUN: begin
                        alu_wr = 1'b1;
                        pc_n   = pc + 16'd1;
                    end
                    K_JR:     pc_n = pc + 16'd1 + {{8{in[7]}}, in};
                    K_RET, K_POP: begin
                        address    = sp;
                        tmp_n[7:0] = in;
                        cp_n       = STEP_2;
                    end
                    K_PUSH: begin
                        address = sp - 16'd1;
                        we      = 1'b1;
                        out     = qq[15:8];
                        cp_n    = STEP_2;
                    end
                    default:  cp_n = STEP_FETCH;
                endcase
            end
            STEP_2: begin
                case (kind)
                    K_LDRRNN: begin
                        pw_en  = 1'b1;
                        pw_val = {in, tmp[7:0]};
                        pc_n   = pc + 16'd1;
                    end
                    K_LDHLN: begin
                        address = hl;
                        we      = 1'b1;
                        out     = tmp[7:0];
                    end
                    K_JP:     pc_n = {in, tmp[7:0]};
                    K_JPCC:   pc_n = cc_true ? {in, tmp[7:0]} : pc + 16'd1;
                    K_CALL: begin
                        tmp_n[15:8] = in;
                        pc_n        = pc + 16'd1;
                        cp_n        = STEP_3;
                    end
                    K_RET: begin
                        address = sp + 16'd1;
                        pc_n    = {in, tmp[7:0]};
                        sp_n    = sp + 16'd2;
                    end
                    K_PUSH: begin
                        address = sp - 16'd2;
                        we      = 1'b1;
                        out     = qq[7:0];
                        sp_n    = sp - 16'd2;
                    end
                    K_POP: begin
                        address = sp + 16'd1;
                        pw_en   = 1'b1;
                        pw_af   = 1'b1;
                        pw_val  = {in, tmp[7:0]};
                        sp_n    = sp + 16'd2;
                    end
                    default:  cp_n = STEP_FETCH;
                endcase
            end
            STEP_3: begin
                if (kind == K_CALL) begin
                    address = sp - 16'd1;
                    we      = 1'b1;
                    out     = pc[15:8];
                    cp_n    = STEP_4;
                end
            end
            STEP_4: begin
                if (kind == K_CALL) begin
                    address = sp - 16'd2;
                    we      = 1'b1;
                    out     = pc[7:0];
                    sp_n    = sp - 16'd2;
                    pc_n    = tmp;
                end
            end
            default: cp_n = STEP_FETCH;
        endcase

        // Register-pair writeback; pw_af selects AF instead of SP for pair 3.
        if (pw_en) begin
            case (p)
                2'd0: begin
                    rf_n[R_B] = pw_val[15:8];
                    rf_n[R_C] = pw_val[7:0];
                end
                2'd1: begin
                    rf_n[R_D] = pw_val[15:8];
                    rf_n[R_E] = pw_val[7:0];
                end
                2'd2: begin
                    rf_n[R_H] = pw_val[15:8];
                    rf_n[R_L] = pw_val[7:0];
                end
                default: begin
                    if (pw_af) begin
                        rf_n[R_A] = pw_val[15:8];
                        rf_n[R_F] = pw_val[7:0];
                    end else begin
                        sp_n = pw_val;
                    end
                end
            endcase
        end
        if (alu_wr) begin
            rf_n[R_A] = alu_out[15:8];
            rf_n[R_F] = alu_out[7:0];
        end
    end

    // State register; ready=0 freezes every piece of state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            sp     <= RESET_SP;
            rf     <= {8'hFF, 8'hFF, 48'h0};
            tmp    <= 16'h0000;
            opc    <= 8'h00;
            cp     <= STEP_FETCH;
            halted <= 1'b0;
        end else if (ready) begin
            pc     <= pc_n;
            sp     <= sp_n;
            rf     <= rf_n;
            tmp    <= tmp_n;
            opc    <= opc_n;
            cp     <= cp_n;
            halted <= halted_n;
        end
    end

endmodule

// File: tb/tb_z80_core_ext.sv
// Directed bench for z80_core_ext: a 64K memory model, programs booted through
// a NOP + JP 0000 stub at the 0100 reset vector, results observed on the bus.
module tb_z80_core_ext;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic [7:0]  mem_in;
    logic [7:0]  out;
    logic        we;
    logic        ready;
    logic        m1;
    logic        halted;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_log [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clock = ~clock;
    assign mem_in = mem[address];

    z80_core_ext #(.RESET_PC(16'h0100), .RESET_SP(16'hFFFF)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .address (address),
        .in      (mem_in),
        .out     (out),
        .we      (we),
        .ready   (ready),
        .m1      (m1),
        .halted  (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: commit a pending write as the memory would on the edge.
    task automatic tick();
        logic        commit;
        logic [15:0] wa;
        logic [7:0]  wd;
        commit = we && ready && reset_n;
        wa     = address;
        wd     = out;
        @(posedge clock);
        @(negedge clock);
        if (commit) begin
            mem[wa] = wd;
            wr_log.push_back(wa);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bytes are taken first-to-last from the most significant used byte of v.
    task automatic load(input logic [15:0] base, input int n, input logic [255:0] v);
        for (int i = 0; i < n; i++) mem[base + 16'(i)] = v[(n-1-i)*8 +: 8];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        wr_log.delete();
        load(16'h0100, 4, 32'h00C3_0000);
    endtask

    task automatic reset_core();
        reset_n = 1'b0;
        ready   = 1'b1;
        ticks(2);
        reset_n = 1'b1;
    endtask

    task automatic boot(input string tag);
        ticks(4);
        check(tag, {16'h0, address}, 32'h0000);
    endtask

    task automatic run_to_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        ready   = 1'b1;

        // Reset state and the reset vector.
        clear_mem();
        reset_core();
        check("rst_addr", {16'h0, address}, 32'h0100);
        check("rst_m1", 32'(m1), 32'd1);
        check("rst_we", 32'(we), 32'd0);
        check("rst_out", {24'h0, out}, 32'h00);
        check("rst_halted", 32'(halted), 32'd0);
        tick();
        check("nop_addr", {16'h0, address}, 32'h0101);
        ticks(3);
        check("jp_addr", {16'h0, address}, 32'h0000);

        // ALU flags, pushed out with PUSH AF after each step.
        clear_mem();
        load(16'h0000, 15, 120'h3E7F_C601_F5_D680_F5_FE01_F5_F603_F5_76);
        reset_core();
        boot("flags_boot");
        run_to_halt("flags_halt", 80);
        check("add_a", {24'h0, mem[16'hFFFE]}, 32'h80);
        check("add_f", {24'h0, mem[16'hFFFD]}, 32'h94);
        check("sub_a", {24'h0, mem[16'hFFFC]}, 32'h00);
        check("sub_f", {24'h0, mem[16'hFFFB]}, 32'h42);
        check("cp_a", {24'h0, mem[16'hFFFA]}, 32'h00);
        check("cp_f", {24'h0, mem[16'hFFF9]}, 32'h93);
        check("or_a", {24'h0, mem[16'hFFF8]}, 32'h03);
        check("or_f", {24'h0, mem[16'hFFF7]}, 32'h04);

        // CALL / RET timing and stack contents.
        clear_mem();
        load(16'h0000, 8, 64'h310020_CD1000_C5_76);
        mem[16'h0010] = 8'hC9;
        reset_core();
        boot("call_boot");
        ticks(3);
        check("ldsp_addr", {16'h0, address}, 32'h0003);
        n = 0;
        do begin tick(); n++; end while (!m1 && n < 20);
        check("call_cycles", n, 5);
        check("call_target", {16'h0, address}, 32'h0010);
        check("call_hi", {24'h0, mem[16'h1FFF]}, 32'h00);
        check("call_lo", {24'h0, mem[16'h1FFE]}, 32'h06);
        n = 0;
        do begin tick(); n++; end while (!m1 && n < 20);
        check("ret_cycles", n, 3);
        check("ret_target", {16'h0, address}, 32'h0006);
        run_to_halt("ret_halt", 20);
        check("ret_wr_count", wr_log.size(), 4);
        check("ret_sp_hi", {16'h0, wr_log[2]}, 32'h1FFF);
        check("ret_sp_lo", {16'h0, wr_log[3]}, 32'h1FFE);

        // PUSH/POP across the 0000/FFFF boundary.
        clear_mem();
        load(16'h0000, 14, 112'h013412_310100_C5_D1_C5_310030_D5_76);
        reset_core();
        boot("wrap_boot");
        run_to_halt("wrap_halt", 80);
        check("wrap_wr_count", wr_log.size(), 6);
        check("push_addr_hi", {16'h0, wr_log[0]}, 32'h0000);
        check("push_addr_lo", {16'h0, wr_log[1]}, 32'hFFFF);
        check("push_mem_hi", {24'h0, mem[16'h0000]}, 32'h12);
        check("push_mem_lo", {24'h0, mem[16'hFFFF]}, 32'h34);
        check("pop_sp_hi", {16'h0, wr_log[2]}, 32'h0000);
        check("pop_sp_lo", {16'h0, wr_log[3]}, 32'hFFFF);
        check("pop_de_hi", {24'h0, mem[16'h2FFF]}, 32'h12);
        check("pop_de_lo", {24'h0, mem[16'h2FFE]}, 32'h34);

        // Wait states on the LD (HL),n write step.
        clear_mem();
        load(16'h0000, 6, 48'h210040_365A_76);
        reset_core();
        boot("wait_boot");
        ticks(3);
        check("ldhl_addr", {16'h0, address}, 32'h0003);
        ticks(2);
        check("wr_step", {15'h0, we, address}, {15'h0, 1'b1, 16'h4000});
        check("wr_data", {24'h0, out}, 32'h5A);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_bus", {7'h0, we, address, out}, {7'h0, 1'b1, 16'h4000, 8'h5A});
        end
        check("stall_no_commit", wr_log.size(), 0);
        ready = 1'b1;
        tick();
        check("wait_commit", wr_log.size(), 1);
        check("wait_mem", {24'h0, mem[16'h4000]}, 32'h5A);
        check("wait_next", {15'h0, m1, address}, {15'h0, 1'b1, 16'h0005});

        // JR backwards onto itself.
        clear_mem();
        load(16'h0000, 2, 16'h18FE);
        reset_core();
        boot("jr_boot");
        tick();
        check("jr_operand", {16'h0, address}, 32'h0001);
        tick();
        check("jr_loop1", {15'h0, m1, address}, {15'h0, 1'b1, 16'h0000});
        ticks(2);
        check("jr_loop2", {15'h0, m1, address}, {15'h0, 1'b1, 16'h0000});

        // JP NZ not taken with Z=1, then HALT freezes the bus.
        clear_mem();
        load(16'h0000, 5, 40'hAF_C23412_76);
        reset_core();
        boot("jpcc_boot");
        tick();
        check("xor_addr", {16'h0, address}, 32'h0001);
        ticks(3);
        check("jpnz_fall", {15'h0, m1, address}, {15'h0, 1'b1, 16'h0004});
        tick();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_addr", {16'h0, address}, 32'h0004);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("halt_hold", {14'h0, halted, m1, we, address},
                  {14'h0, 1'b1, 1'b1, 1'b0, 16'h0004});
        end
        check("halt_no_write", wr_log.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/z80_core_ext.md
Name: z80_core_ext

Overview:
- Second-generation multi-cycle Z80-subset CPU core for the mini FPGA builds.
- Keeps the one-bus-step-per-clock model: a single address bus, combinational we/out, and a step counter cp where cp=0 is the opcode fetch.
- New relative to the first generation:
  - parametrised reset vector and stack pointer;
  - memory wait handshake;
  - ALU instructions with the full Z80 flag register;
  - jumps, CALL/RET, PUSH/POP;
  - halted and m1 status outputs.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
RESET_SP, 16'hFFFF, SP value loaded on reset

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous active-low reset
address  out  16  memory address, combinational from state (PC, HL or SP-derived)
in  in  8  memory read data, valid in the same cycle as address
out  out  8  memory write data, combinational
we  out  1  write strobe, combinational; the write commits on a clock edge where ready=1
ready  in  1  memory ready; 0 stalls the core
m1  out  1  1 when cp=0 (opcode fetch step)
halted  out  1  1 after HALT executes

Behaviour:
- Reset is applied on posedge clock when reset_n=0.
  - Register reset values: PC=RESET_PC, SP=RESET_SP, AF=16'hFFFF, BC=DE=HL=0, cp=0, halted=0.
  - Output values after reset: address=RESET_PC, we=0, out=0, m1=1.
  - Reset mid-instruction aborts the instruction; no partial register write occurs on the reset edge.
- Stall: when ready=0, the edge updates nothing (pc, cp, tmp, registers, flags all hold). address, we and out stay stable, so a write is held until ready=1.
- Step mapping:
  - cp=0: opcode on in; the opcode is latched into opc.
  - cp>0: the step decodes from opc.
  - The last step of every instruction returns cp to 0.
- F bit layout: S=7, Z=6, bit5=0, H=4, bit3=0, P/V=2, N=1, C=0.
- Instruction steps (each count includes cp=0):
  - NOP 00 (1).
  - LD rr,nn (3).
  - INC/DEC rr (1), no flags.
  - LD r,n (2).
  - LD (HL),n (3).
  - LD r,r' (1).
  - LD r,(HL) (2).
  - LD (HL),r (2).
  - ALU A,r 10ooosss (1).
  - ALU A,(HL) (2).
  - ALU A,n 11ooo110 (2).
  - JP nn C3 (3).
  - JP cc,nn 11ccc010 (3); operands are always fetched, PC loads only if cc is true. cc order: NZ,Z,NC,C,PO,PE,P,M.
  - JR e 18 (2): PC = address_of_opcode + 2 + sign_extend(e), modulo 2^16.
  - CALL nn CD (5):
    - steps 1–2 fetch nn;
    - step 3 writes the return address high byte to SP-1;
    - step 4 writes the return address low byte to SP-2, then SP-=2 and PC=nn.
  - RET C9 (3): read (SP) low, then (SP+1) high; SP+=2; PC={hi,lo}.
  - PUSH qq 11qq0101 (3): writes the high byte to SP-1, then the low byte to SP-2; SP-=2.
  - POP qq 11qq0001 (3): reads the low byte from SP, then the high byte from SP+1; SP+=2. qq=3 selects AF; POP AF loads F verbatim.
  - HALT 76 (1): PC not advanced; halted=1. The core then stays at cp=0 with address=PC, we=0 until reset.
  - All other opcodes: 1-step NOP.
- SP arithmetic wraps modulo 2^16 (0000-1 = FFFF).
- ALU ops ooo: ADD, ADC, SUB, SBC, AND, XOR, OR, CP. A is unchanged for CP.
  - S = result[7]; Z = (result==0).
  - Arithmetic ops:
    - H = carry/borrow out of bit 3.
    - P/V = signed overflow.
    - C = carry/borrow out of bit 7.
    - N = 1 for SUB/SBC/CP, else 0.
  - Logic ops: P/V = even parity, N=0, C=0; H=1 for AND, H=0 for OR/XOR.
- Write steps: we=1 with out = the data byte. All other steps have we=0 and out=0.

Test Plan:
- Reset with RESET_PC=16'h0100: after the reset edge, address=0100, m1=1, we=0, halted=0. After one NOP at 0100, address=0101.
- Flags check: program 3E 7F C6 01 (LD A,7F; ADD A,01) -> A=80, F: S=1, Z=0, H=1, P/V=1, N=0, C=0. Then D6 80 (SUB 80) -> A=00, Z=1, N=1, C=0.
- Call/return: 31 00 20 CD 10 00 at 0000, C9 at 0010 (LD SP,2000; CALL 0010) -> 1FFF=00, 1FFE=06, SP=1FFE; after RET, PC=0006, SP=2000. Cycle counts are 5 and 3 steps.
- Stack and wrap: BC=1234, SP=0001, PUSH BC -> mem[0000]=12, mem[FFFF]=34, SP=FFFF; POP DE -> DE=1234, SP=0001.
- Wait states: hold ready=0 for 3 cycles during the LD (HL),n write step -> we stays 1 with stable address/out; exactly one write is committed; total latency is 3+3 cycles.
- Branches and halt: JR FE at 0000 loops at 0000. JP NZ,1234 with Z=1 falls through to PC+3. 76 -> halted=1, address frozen at the HALT address for 10+ cycles.
